// File: rtl/riscv_pkg.sv
// Shared types and constants for the CPU memory arbiter slice.
package riscv_pkg;

    // Arbiter FSM: port free to grant, or a read in flight.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // Which requester owns the outstanding read.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Read-latency down-counter width; holds MEM_LAT-1 for MEM_LAT up to 4.
    localparam int LAT_W = 2;

    // All-ones byte-enable source, sliced to the data width by the user.
    localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/riscv_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, a tie goes to the
// side that was not granted last. Bit 0 is fetch, bit 1 is load/store.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // rr_q = 1 means side 1 wins the next tie.
    logic rr_q;
    logic rr_d;

    // Pick a one-hot winner when the port can accept a new access.
    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Point the tie-break at the side that just lost.
    always_comb begin
        rr_d = rr_q;
        if (gnt[0]) begin
            rr_d = 1'b1;
        end else if (gnt[1]) begin
            rr_d = 1'b0;
        end
    end

    // Pointer register; reset favours fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and the
// load/store unit. Stores finish in the grant cycle; reads are tracked
// through the fixed SRAM latency and returned with a one-cycle rvalid.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk_150_mhz,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [15:0]         if_stall_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0]  FETCH_BE = BE_ALL[BE_W-1:0];
    localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    logic [15:0]      stall_q, stall_d;

    logic       port_free;
    logic       rd_done;
    logic       rd_gnt;
    logic [1:0] gnt;

    // Byte offsets are dropped on the way to the word-addressed SRAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    assign port_free = (state_q == IDLE) || (cnt_q == '0);
    // Gating with rst_n keeps a read interrupted by reset from returning.
    assign rd_done   = rst_n && (state_q == RD_WAIT) && (cnt_q == '0);
    assign busy      = rst_n && (state_q == RD_WAIT);

    rr_arb2 u_rr_arb2 (
        .clk     (clk_150_mhz),
        .rst_n   (rst_n),
        .req     ({d_req, if_req}),
        .advance (rst_n && port_free),
        .gnt     (gnt)
    );

    assign if_gnt       = gnt[0];
    assign d_gnt        = gnt[1];
    assign if_stall_cnt = stall_q;

    // Route the winner onto the SRAM port; idle port drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_en   = 1'b1;
            mem_be   = FETCH_BE;
            mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
        end else if (gnt[1]) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = d_wdata;
        end
    end

    // Return read data to the recorded owner only in the completion cycle.
    always_comb begin
        if_rvalid = rd_done && (owner_q == OWN_IF);
        d_rvalid  = rd_done && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

    // Next-state: a read grant (re)arms the latency counter, otherwise count
    // down and fall back to IDLE once the data has been handed over.
    always_comb begin
        rd_gnt  = gnt[0] || (gnt[1] && !d_we);
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (rd_gnt) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_LOAD;
            owner_d = gnt[1] ? OWN_D : OWN_IF;
        end else if (state_q == RD_WAIT) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end
        stall_d = stall_q;
        if (if_req && !gnt[0] && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // FSM and stall-counter registers.
    always_ff @(posedge clk_150_mhz) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: instance a uses MEM_LAT=1 (table-driven),
// instance b uses MEM_LAT=3 (hand-written multi-cycle sequences).
module tb_riscv_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance a (MEM_LAT=1) ----------------
    logic        rst_a, if_req_a, d_req_a, d_we_a;
    logic [31:0] if_addr_a, d_addr_a, d_wdata_a;
    logic [3:0]  d_be_a;
    logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        mem_en_a, mem_we_a, busy_a;
    logic [3:0]  mem_be_a;
    logic [15:0] stall_a;

    // ---------------- instance b (MEM_LAT=3) ----------------
    logic        rst_b, if_req_b, d_req_b, d_we_b;
    logic [31:0] if_addr_b, d_addr_b, d_wdata_b;
    logic [3:0]  d_be_b;
    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_en_b, mem_we_b, busy_b;
    logic [3:0]  mem_be_b;
    logic [15:0] stall_b;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk_150_mhz(clk), .rst_n(rst_a),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_be(d_be_a), .d_addr(d_addr_a),
        .d_wdata(d_wdata_a), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_be(mem_be_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .if_stall_cnt(stall_a)
    );

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk_150_mhz(clk), .rst_n(rst_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_be(d_be_b), .d_addr(d_addr_b),
        .d_wdata(d_wdata_b), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .if_stall_cnt(stall_b)
    );

    // Memory contents as a function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // SRAM models; read data shows junk when no read is landing.
    logic        pa_v = 1'b0;
    logic [31:0] pa_d = 32'h0;
    always @(posedge clk) begin
        pa_v <= mem_en_a && !mem_we_a;
        pa_d <= mem_word(mem_addr_a);
    end
    assign mem_rdata_a = pa_v ? pa_d : 32'hDEAD_BEEF;

    logic [2:0]  pb_v = 3'b000;
    logic [31:0] pb_d [3];
    always @(posedge clk) begin
        pb_v    <= {pb_v[1:0], mem_en_b && !mem_we_b};
        pb_d[0] <= mem_word(mem_addr_b);
        pb_d[1] <= pb_d[0];
        pb_d[2] <= pb_d[1];
    end
    assign mem_rdata_b = pb_v[2] ? pb_d[2] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected read returns.
    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always @(negedge clk) begin
        if (if_rvalid_a || d_rvalid_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ret_a_unexpected: got if_rvalid=%b d_rvalid=%b want none (cycle %0d)",
                         if_rvalid_a, d_rvalid_a, cyc);
            end else begin
                e_a = q_a.pop_front();
                chk("ret_a", {d_rvalid_a, if_rvalid_a, (d_rvalid_a ? d_rdata_a : if_rdata_a), cyc},
                    {e_a.is_d, !e_a.is_d, e_a.data, e_a.cyc});
            end
        end
        chk("leak_a", {(if_rvalid_a ? 32'h0 : if_rdata_a), (d_rvalid_a ? 32'h0 : d_rdata_a)}, 128'h0);
    end

    always @(negedge clk) begin
        if (if_rvalid_b || d_rvalid_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ret_b_unexpected: got if_rvalid=%b d_rvalid=%b want none (cycle %0d)",
                         if_rvalid_b, d_rvalid_b, cyc);
            end else begin
                e_b = q_b.pop_front();
                chk("ret_b", {d_rvalid_b, if_rvalid_b, (d_rvalid_b ? d_rdata_b : if_rdata_b), cyc},
                    {e_b.is_d, !e_b.is_d, e_b.data, e_b.cyc});
            end
        end
        chk("leak_b", {(if_rvalid_b ? 32'h0 : if_rdata_b), (d_rvalid_b ? 32'h0 : d_rdata_b)}, 128'h0);
    end

    // One table row = one cycle of stimulus for instance a plus its expectations.
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_ig;
        logic        e_dg;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [3:0] dbe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic e_ig, input logic e_dg,
                                input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_addr, input logic [31:0] e_wd,
                                input logic e_busy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.e_ig = e_ig; v.e_dg = e_dg; v.e_we = e_we; v.e_be = e_be;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    localparam int NV = 19;
    localparam logic [31:0] G  = 32'hFFFF_FFFF;
    localparam logic [31:0] GW = 32'hCAFE_F00D;
    vec_t vecs [NV];

    initial begin
        // idle
        vecs[0]  = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 0);
        // tie, loads only: IF, D, IF, D, IF, D
        vecs[1]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 1, 0, 0, 4'hF, 32'h300, 32'h0, 0);
        vecs[2]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 0, 1, 0, 4'hF, 32'h200, GW,    1);
        vecs[3]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 1, 0, 0, 4'hF, 32'h300, 32'h0, 1);
        vecs[4]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 0, 1, 0, 4'hF, 32'h200, GW,    1);
        vecs[5]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 1, 0, 0, 4'hF, 32'h300, 32'h0, 1);
        vecs[6]  = mk(1, 32'h300, 1, 0, 4'hF, 32'h200, GW, 0, 1, 0, 4'hF, 32'h200, GW,    1);
        vecs[7]  = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 1);
        // lone misaligned fetch
        vecs[8]  = mk(1, 32'h106, 0, 1, 4'hF, G,    GW,   1, 0, 0, 4'hF, 32'h104, 32'h0, 0);
        vecs[9]  = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 1);
        // back-to-back stores
        vecs[10] = mk(0, G, 1, 1, 4'b0011, 32'h1003, 32'hAAAA_0001, 0, 1, 1, 4'b0011, 32'h1000, 32'hAAAA_0001, 0);
        vecs[11] = mk(0, G, 1, 1, 4'b0011, 32'h1003, 32'hAAAA_0002, 0, 1, 1, 4'b0011, 32'h1000, 32'hAAAA_0002, 0);
        vecs[12] = mk(0, G, 1, 1, 4'b0011, 32'h1003, 32'hAAAA_0003, 0, 1, 1, 4'b0011, 32'h1000, 32'hAAAA_0003, 0);
        // tie store vs fetch after a store: fetch wins, store follows in the return cycle
        vecs[13] = mk(1, 32'h50, 1, 1, 4'b0011, 32'h1003, 32'hBBBB_0001, 1, 0, 0, 4'hF, 32'h50, 32'h0, 0);
        vecs[14] = mk(0, G,      1, 1, 4'b0011, 32'h1003, 32'hBBBB_0001, 0, 1, 1, 4'b0011, 32'h1000, 32'hBBBB_0001, 1);
        vecs[15] = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 0);
        // lone misaligned load
        vecs[16] = mk(0, 32'h7777, 1, 0, 4'hF, 32'h2FF, GW, 0, 1, 0, 4'hF, 32'h2FC, GW, 0);
        vecs[17] = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 1);
        vecs[18] = mk(0, G,     0, 1, 4'hF, G,     GW,   0, 0, 0, 4'h0, 32'h0,   32'h0, 0);

        // ---------------- reset with both requests high ----------------
        rst_a = 0; if_req_a = 1; d_req_a = 1; d_we_a = 0; d_be_a = 4'hF;
        if_addr_a = 32'h10; d_addr_a = 32'h20; d_wdata_a = 32'h0;
        rst_b = 0; if_req_b = 1; d_req_b = 1; d_we_b = 0; d_be_b = 4'hF;
        if_addr_b = 32'h10; d_addr_b = 32'h20; d_wdata_b = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_a", {if_gnt_a, d_gnt_a, mem_en_a, busy_a, stall_a}, 128'h0);
            chk("reset_b", {if_gnt_b, d_gnt_b, mem_en_b, busy_b, stall_b}, 128'h0);
        end
        @(posedge clk); #1;
        rst_a = 1; if_req_a = 0; d_req_a = 0;
        rst_b = 1; if_req_b = 0; d_req_b = 0;

        // ---------------- instance a: table ----------------
        for (int i = 0; i < NV; i++) begin
            if_req_a = vecs[i].ir;  if_addr_a = vecs[i].ia;
            d_req_a  = vecs[i].dr;  d_we_a    = vecs[i].dw;  d_be_a = vecs[i].dbe;
            d_addr_a = vecs[i].da;  d_wdata_a = vecs[i].dwd;
            @(negedge clk);
            chk($sformatf("vec_a%0d", i),
                {if_gnt_a, d_gnt_a, mem_en_a, mem_we_a, mem_be_a, mem_addr_a, mem_wdata_a, busy_a},
                {vecs[i].e_ig, vecs[i].e_dg, vecs[i].e_ig | vecs[i].e_dg, vecs[i].e_we,
                 vecs[i].e_be, vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_busy});
            if (vecs[i].e_ig)
                q_a.push_back('{1'b0, mem_word(vecs[i].e_addr), cyc + 1});
            if (vecs[i].e_dg && !vecs[i].dw)
                q_a.push_back('{1'b1, mem_word(vecs[i].e_addr), cyc + 1});
            @(posedge clk); #1;
        end
        if_req_a = 0; d_req_a = 0;
        @(negedge clk);
        chk("stall_a", stall_a, 128'd3);
        @(posedge clk); #1;

        // ---------------- instance b: MEM_LAT=3 ----------------
        // lone fetch so the next tie favours the load
        if_req_b = 1; if_addr_b = 32'h40;
        @(negedge clk);
        chk("b_fetch_gnt", {if_gnt_b, d_gnt_b, mem_addr_b}, {1'b1, 1'b0, 32'h40});
        q_b.push_back('{1'b0, mem_word(32'h40), cyc + 3});
        @(posedge clk); #1;
        if_req_b = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("b_fetch_busy%0d", k), busy_b, 128'd1);
            @(posedge clk); #1;
        end

        // load granted at T, fetch pending from T
        d_req_b = 1; d_we_b = 0; d_be_b = 4'hF; d_addr_b = 32'h80;
        if_req_b = 1; if_addr_b = 32'h44;
        @(negedge clk);
        chk("b_load_gnt", {if_gnt_b, d_gnt_b, busy_b}, {1'b0, 1'b1, 1'b0});
        q_b.push_back('{1'b1, mem_word(32'h80), cyc + 3});
        @(posedge clk); #1;
        d_req_b = 0; d_addr_b = 32'hFFFF_FFF0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk($sformatf("b_wait%0d", k), {busy_b, if_gnt_b, d_gnt_b, mem_en_b}, {1'b1, 1'b0, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b_if_after_load", {busy_b, if_gnt_b, mem_addr_b}, {1'b1, 1'b1, 32'h44});
        chk("b_stall", stall_b, 128'd3);
        q_b.push_back('{1'b0, mem_word(32'h44), cyc + 3});
        @(posedge clk); #1;
        if_req_b = 0;
        @(negedge clk);
        chk("b_stall_hold", stall_b, 128'd3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b_idle", {busy_b, mem_en_b}, 128'h0);
        @(posedge clk); #1;

        // reset in the cycle after a load grant
        d_req_b = 1; d_we_b = 0; d_addr_b = 32'h90;
        @(negedge clk);
        chk("b_rst_load_gnt", d_gnt_b, 128'd1);
        @(posedge clk); #1;
        d_req_b = 0; rst_b = 0;
        @(negedge clk);
        chk("b_in_reset", {d_rvalid_b, if_gnt_b, d_gnt_b, mem_en_b}, 128'h0);
        @(posedge clk); #1;
        rst_b = 1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("b_after_reset%0d", k), {busy_b, d_rvalid_b, d_rdata_b}, 128'h0);
            @(posedge clk); #1;
        end

        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("q_a_empty", q_a.size(), 128'd0);
        chk("q_b_empty", q_b.size(), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Single-port memory arbiter that lets the instruction-fetch stage and the load/store unit of `riscv_cpu` share one unified synchronous SRAM. It grants at most one requester per cycle using two-way round-robin, and sequences reads through a fixed memory read latency. It returns read data to the granted requester with a one-cycle valid pulse. It sits between the CPU core and the memory macro, clocked by the core clock.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data width. Byte enables are `DATA_W/8` bits wide.
- `MEM_LAT`, 1, SRAM read latency in cycles. Legal range is 1..4.

Ports:
- `clk_150_mhz` in 1: core clock. This is the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_W: fetch byte address.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out DATA_W: fetch read data.
- `d_req` in 1: load/store request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in DATA_W/8: store byte enables.
- `d_addr` in ADDR_W: load/store byte address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: load/store granted.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out DATA_W: load data.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 1: SRAM write enable.
- `mem_be` out DATA_W/8: SRAM byte enables.
- `mem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata` out DATA_W: SRAM write data.
- `mem_rdata` in DATA_W: SRAM read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy` out 1: a read is outstanding.
- `if_stall_cnt` out 16: saturating count of cycles with `if_req && !if_gnt`.

## Operation
- FSM states:
  - `IDLE`: free to grant.
  - `RD_WAIT`: read outstanding, with down-counter `cnt`.
- Grant eligibility:
  - Grants are issued only when the port is free: state `IDLE`, or `RD_WAIT` with `cnt==0`.
  - `gnt` is combinational from `req`, the state and the round-robin pointer `rr`.
- Arbitration:
  - A lone requester wins.
  - On a tie, the side not granted last wins.
  - `rr` updates on every grant.
  - Reset sets `rr` so that fetch wins the first tie.
- Access routing:
  - On grant, `mem_en=1` and the winner's address, write enable, byte enables and data drive the SRAM in the same cycle.
  - Fetch always drives `we=0`, `be=all ones`, `wdata=0`.
- Store: completes in the grant cycle. There is no `d_rvalid`. The state stays `IDLE`, so back-to-back grants are allowed every cycle.
- Read (fetch or load):
  - On grant, go to `RD_WAIT` with `cnt=MEM_LAT-1` and record the owner.
  - While in `RD_WAIT`, decrement `cnt` each cycle.
  - When `cnt==0`, assert the owner's `rvalid` for exactly one cycle, with `rdata=mem_rdata` passed through.
  - A new grant may issue in that same cycle. Without a new read grant, return to `IDLE`.
- Outputs when not granting: `mem_*` are 0. Each `*_rdata` is 0 unless its `rvalid` is high.
- Requester rule: address, `we`, `be` and `wdata` are held stable while `req` is high and `gnt` is low.
- Starvation bound: a requester waits at most one foreign transaction.
- `if_stall_cnt` saturates at 16'hFFFF.
- Misaligned addresses are not flagged. The low 2 bits are dropped.

## Timing
- Reset values: all outputs are 0, state is `IDLE`, `cnt=0`, `rr` favours fetch, `if_stall_cnt=0`.
- Grant latency: 0 cycles from `req` when the port is free.
- Read latency: grant in cycle T gives `rvalid` in cycle T+MEM_LAT.
- Throughput:
  - Reads: one per MEM_LAT cycles.
  - Stores: one per cycle.
- Reset mid-read: the outstanding read is abandoned. No `rvalid` appears after `rst_n` deasserts, and a stale `mem_rdata` is never forwarded.
- `req` falling while in `RD_WAIT` has no effect on the outstanding read.

## Structure
- Shared package `riscv_pkg`:
  - FSM state enum (`IDLE`, `RD_WAIT`).
  - Owner enum (`OWN_IF`, `OWN_D`).
  - Constants `BE_ALL`, `LAT_W`.
- One natural sub-module: `rr_arb2`, a two-input round-robin arbiter. It takes `req[1:0]` and the `advance` signal, and outputs a one-hot `gnt[1:0]`.
- Everything else stays in `riscv_mem_arbiter`.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with both `req=1`. Required: `if_gnt=d_gnt=mem_en=0`, `busy=0`, `if_stall_cnt=0`.
- Lone fetch, MEM_LAT=1: `if_req=1`, `if_addr=32'h0000_0106`. Required:
  - Cycle T: `if_gnt=1`, `mem_addr=32'h0000_0104`, `mem_be=4'hF`.
  - Cycle T+1: `if_rvalid=1`, `if_rdata` equals the memory word.
- Tie fairness: both `req` held high for 6 cycles, loads only, MEM_LAT=1. Required: grants alternate IF, D, IF, D…, with fetch first after reset.
- Stores back-to-back: `d_req` with `d_we=1`, `d_be=4'b0011`, 3 consecutive cycles. Required: `d_gnt=1` every cycle, `mem_we=1`, `mem_be=4'b0011`, no `d_rvalid`.
- MEM_LAT=3: load granted at T. Required:
  - `busy=1` in T+1..T+3.
  - `d_rvalid` only at T+3.
  - A pending fetch is granted at T+3.
  - `if_stall_cnt` increments by 3.
- Reset mid-read: MEM_LAT=3, assert `rst_n=0` at T+1. Required: no `d_rvalid` at T+3 or later, and the state returns to `IDLE`.
